irq_pending_latch: RTL and testbench

- Upstream stage of priority_encoder. Synchronises 8 asynchronous request lines and turns them into sticky pending bits, either on rising edges or on levels.
- Presents the masked pending vector directly to the encoder's ui_in.
- Clears a bit when the downstream consumer acknowledges the granted index.
- Counts events lost because their bit was already pending.

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_pending_latch_bit_sync.sv | 30 +++
 rtl/irq_pending_latch.sv | 97 +++++++++
 tb/tb_irq_pending_latch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending-latch front end
// that feeds priority_encoder.
package irq_pkg;

  localparam int IRQ_WIDTH = 8;
  localparam int IRQ_IDX_W = 3;
  localparam int IRQ_CNT_W = 8;

  typedef logic [IRQ_WIDTH-1:0] irq_vec_t;
  typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

endpackage

// File: rtl/irq_pending_latch_bit_sync.sv
// Vector of multi-flop synchronisers; every bit of d_i passes through STAGES
// flops (STAGES >= 2) that reset asynchronously to 0.
module bit_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/irq_pending_latch.sv
// Synchronises raw request lines into sticky pending bits, clears them on
// consumer acknowledge, and counts events lost to already-pending bits.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int WIDTH       = IRQ_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1,
  parameter int CNT_W       = IRQ_CNT_W,
  localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             flush,
  output logic [WIDTH-1:0] pend_out,
  output logic             pend_any,
  output logic             ack_err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SUM_W = CNT_W + IDX_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{IDX_W{1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] syncDly_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
  logic             ackErr_q, ackErr_d;

  logic [WIDTH-1:0] setVec, hitVec, clrVec, dropVec;
  logic [SUM_W-1:0] dropSum;

  bit_sync #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(req_in),
    .q_o(sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncDly_q <= '0;
      pending_q <= '0;
      dropCnt_q <= '0;
      ackErr_q  <= 1'b0;
    end else begin
      syncDly_q <= sync;
      pending_q <= pending_d;
      dropCnt_q <= dropCnt_d;
      ackErr_q  <= ackErr_d;
    end
  end

  always_comb begin
    setVec = EDGE_MODE ? (sync & ~syncDly_q) : sync;

    hitVec = '0;
    if (ack_valid && (32'(ack_idx) < 32'(WIDTH))) begin
      hitVec[ack_idx] = 1'b1;
    end
    clrVec = hitVec & pending_q;

    // An out-of-range or non-pending target leaves clrVec empty, which is
    // exactly the error condition; such an ack therefore changes no state.
    ackErr_d = ack_valid & ~(|clrVec);

    // A set coinciding with a clear re-arms the bit instead of losing it.
    pending_d = flush ? '0 : ((pending_q & ~clrVec) | setVec);
    dropVec   = setVec & pending_q & ~clrVec & {WIDTH{~flush}};

    dropSum = {{IDX_W{1'b0}}, dropCnt_q};
    for (int i = 0; i < WIDTH; i++) begin
      dropSum = dropSum + SUM_W'(dropVec[i]);
    end

    if (flush) begin
      dropCnt_d = '0;
    end else if (dropSum > CNT_MAX) begin
      dropCnt_d = CNT_MAX[CNT_W-1:0];
    end else begin
      dropCnt_d = dropSum[CNT_W-1:0];
    end
  end

  assign pend_out = pending_q & ~mask;
  assign pend_any = |pend_out;
  assign ack_err  = ackErr_q;
  assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: an edge-mode and a level-mode
// instance share one set of stimulus lines.
module tb_irq_pending_latch;
  import irq_pkg::*;

  typedef struct {
    irq_vec_t   req;
    irq_vec_t   mask;
    logic       ackValid;
    irq_idx_t   ackIdx;
    logic       flush;
    irq_vec_t   expPend;
    logic       expAny;
    logic       expErr;
    logic [7:0] expDrop;
  } vector_t;

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  irq_vec_t reqIn = '0;
  irq_vec_t mask = '0;
  logic     ackValid = 1'b0;
  irq_idx_t ackIdx = '0;
  logic     flush = 1'b0;

  irq_vec_t   pendOutE, pendOutL;
  logic       pendAnyE, pendAnyL;
  logic       ackErrE, ackErrL;
  logic [7:0] dropCntE, dropCntL;

  int passCount = 0;
  int checkCount = 0;

  vector_t vecs[20];

  irq_pending_latch #(.EDGE_MODE(1'b1)) dutE (
    .clk(clk), .rst(rst), .req_in(reqIn), .mask(mask),
    .ack_valid(ackValid), .ack_idx(ackIdx), .flush(flush),
    .pend_out(pendOutE), .pend_any(pendAnyE), .ack_err(ackErrE), .drop_cnt(dropCntE)
  );

  irq_pending_latch #(.EDGE_MODE(1'b0)) dutL (
    .clk(clk), .rst(rst), .req_in(reqIn), .mask(mask),
    .ack_valid(ackValid), .ack_idx(ackIdx), .flush(flush),
    .pend_out(pendOutL), .pend_any(pendAnyL), .ack_err(ackErrL), .drop_cnt(dropCntL)
  );

  always #5 clk = ~clk;

  function automatic vector_t mk(input irq_vec_t r, input irq_vec_t m, input logic av,
                                 input irq_idx_t ai, input logic f, input irq_vec_t ep,
                                 input logic ea, input logic ee, input logic [7:0] ed);
    vector_t v;
    v.req = r; v.mask = m; v.ackValid = av; v.ackIdx = ai; v.flush = f;
    v.expPend = ep; v.expAny = ea; v.expErr = ee; v.expDrop = ed;
    return v;
  endfunction

  // Drive inputs on the falling edge, then let one rising edge pass.
  task automatic applyStimulus(input irq_vec_t r, input irq_vec_t m, input logic av,
                               input irq_idx_t ai, input logic f);
    @(negedge clk);
    reqIn = r; mask = m; ackValid = av; ackIdx = ai; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    // Edge-mode sequence: latency, ack/clear, ack error, ack racing a new
    // rise, drop count, masked ack, flush.
    vecs[0]  = mk(8'h24, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'd0);
    vecs[1]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'd0);
    vecs[2]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h24, 1, 0, 8'd0);
    vecs[3]  = mk(8'h00, 8'h00, 1, 3'd5, 0, 8'h04, 1, 0, 8'd0);
    vecs[4]  = mk(8'h00, 8'h00, 1, 3'd5, 0, 8'h04, 1, 1, 8'd0);
    vecs[5]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd0);
    vecs[6]  = mk(8'h04, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd0);
    vecs[7]  = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd0);
    vecs[8]  = mk(8'h00, 8'h00, 1, 3'd2, 0, 8'h04, 1, 0, 8'd0);
    vecs[9]  = mk(8'h04, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd0);
    vecs[10] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd0);
    vecs[11] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd1);
    vecs[12] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h04, 1, 0, 8'd1);
    vecs[13] = mk(8'h00, 8'h04, 0, 3'd0, 0, 8'h00, 0, 0, 8'd1);
    vecs[14] = mk(8'h00, 8'h04, 1, 3'd2, 0, 8'h00, 0, 0, 8'd1);
    vecs[15] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'd1);
    vecs[16] = mk(8'h10, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'd1);
    vecs[17] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h00, 0, 0, 8'd1);
    vecs[18] = mk(8'h00, 8'h00, 0, 3'd0, 0, 8'h10, 1, 0, 8'd1);
    vecs[19] = mk(8'h00, 8'h00, 0, 3'd0, 1, 8'h00, 0, 0, 8'd0);

    #2 rst = 1'b1;
    #1;
    checkOutput("reset pend_out", 32'(pendOutE), 32'h00);
    checkOutput("reset pend_any", 32'(pendAnyE), 32'h0);
    checkOutput("reset ack_err", 32'(ackErrE), 32'h0);
    checkOutput("reset drop_cnt", 32'(dropCntE), 32'h00);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2) applyStimulus(8'h00, 8'h00, 0, 3'd0, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].req, vecs[i].mask, vecs[i].ackValid, vecs[i].ackIdx, vecs[i].flush);
      checkOutput($sformatf("vec%0d pend_out", i), 32'(pendOutE), 32'(vecs[i].expPend));
      checkOutput($sformatf("vec%0d pend_any", i), 32'(pendAnyE), 32'(vecs[i].expAny));
      checkOutput($sformatf("vec%0d ack_err", i), 32'(ackErrE), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d drop_cnt", i), 32'(dropCntE), 32'(vecs[i].expDrop));
    end

    // Fully masked rises stay hidden, then appear the moment the mask drops.
    applyStimulus(8'h81, 8'hFF, 0, 3'd0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 3'd0, 0);
    applyStimulus(8'h00, 8'hFF, 0, 3'd0, 0);
    checkOutput("masked pend_out", 32'(pendOutE), 32'h00);
    checkOutput("masked pend_any", 32'(pendAnyE), 32'h0);
    @(negedge clk) mask = 8'h00;
    #1;
    checkOutput("unmask pend_out", 32'(pendOutE), 32'h81);
    checkOutput("unmask pend_any", 32'(pendAnyE), 32'h1);
    applyStimulus(8'h00, 8'h00, 0, 3'd0, 1);
    checkOutput("flush1 pend_out", 32'(pendOutE), 32'h00);

    // Level mode with line 3 held high: one drop per cycle after the first.
    for (int i = 0; i < 10; i++) applyStimulus(8'h08, 8'h00, 0, 3'd0, 0);
    checkOutput("level pend_out", 32'(pendOutL), 32'h08);
    checkOutput("level drop_cnt early", 32'(dropCntL), 32'd7);
    for (int i = 0; i < 290; i++) applyStimulus(8'h08, 8'h00, 0, 3'd0, 0);
    checkOutput("level drop_cnt sat", 32'(dropCntL), 32'hFF);
    checkOutput("edge held drop_cnt", 32'(dropCntE), 32'h00);
    checkOutput("edge held pend_out", 32'(pendOutE), 32'h08);
    repeat (3) applyStimulus(8'h00, 8'h00, 0, 3'd0, 0);
    applyStimulus(8'h00, 8'h00, 0, 3'd0, 1);
    checkOutput("flush2 level pend_out", 32'(pendOutL), 32'h00);
    checkOutput("flush2 level drop_cnt", 32'(dropCntL), 32'h00);
    checkOutput("flush2 edge pend_out", 32'(pendOutE), 32'h00);

    // Asynchronous reset mid-stream, then release with line 0 held high.
    applyStimulus(8'hA5, 8'h00, 0, 3'd0, 0);
    applyStimulus(8'h00, 8'h00, 0, 3'd0, 0);
    applyStimulus(8'h00, 8'h00, 0, 3'd0, 0);
    checkOutput("pre-reset pend_out", 32'(pendOutE), 32'hA5);
    @(negedge clk);
    #2 rst = 1'b1;
    reqIn = 8'h01;
    #1;
    checkOutput("async reset pend_out", 32'(pendOutE), 32'h00);
    checkOutput("async reset pend_any", 32'(pendAnyE), 32'h0);
    checkOutput("async reset level pend_out", 32'(pendOutL), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("post-reset edge2 pend_out", 32'(pendOutE), 32'h00);
    @(posedge clk);
    #1;
    checkOutput("post-reset edge3 pend_out", 32'(pendOutE), 32'h01);
    checkOutput("post-reset edge3 level pend_out", 32'(pendOutL), 32'h01);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
